apb_periph_hub: RTL and testbench
=================================

Name: apb_periph_hub

Overview:
- Parametrised APB I/O hub between the FpgaSystem I/O APB master port and up to 8 peripheral slaves (UARTs, GPIO, timers).
- Decodes paddr[15:8] into per-slave selects and muxes read data and ready back to the master.
- Completes stalled or unmapped accesses with a timeout and error record.
- Aggregates slave interrupts into the single active-low n_int line of BrewV1Top, with mask, pending and level/edge mode registers.

Parameters:
- NUM_SLAVES, 4, number of downstream slave channels (1..8).
- BASE_PAGE, 8'h00, page of slave 0; slave i sits at page BASE_PAGE+i.
- HUB_PAGE, 8'hFF, page of the hub's own registers; must not overlap slave pages.
- TIMEOUT, 64, access-phase cycles without slave pready before abort (2..255).

Ports:
- clk  in  1  single clock for hub, master and slaves.
- n_rst  in  1  asynchronous, active-low reset.
- paddr  in  16  master address.
- pwdata  in  8  master write data.
- pwrite  in  1  master write strobe.
- psel  in  1  master select.
- penable  in  1  master enable.
- prdata  out  8  read data to master.
- pready  out  1  ready to master.
- s_paddr  out  8  paddr[7:0], shared by all slaves.
- s_pwdata  out  8  shared write data.
- s_pwrite  out  1  shared write strobe.
- s_penable  out  1  shared enable.
- s_psel  out  NUM_SLAVES  one-hot slave select.
- s_prdata  in  8*NUM_SLAVES  slave read data; slave i on bits [8i+7:8i].
- s_pready  in  NUM_SLAVES  slave ready.
- irq_in  in  NUM_SLAVES  slave interrupt requests, active-high, synchronous to clk.
- n_int  out  1  aggregated interrupt, active-low, registered.

Behaviour:
- Reset (n_rst low, asynchronous):
  - FSM goes to IDLE.
  - INT_MASK, INT_EDGE, INT_PENDING, ERR_FLAG and ERR_PAGE clear to 0.
  - n_int = 1.
  - Combinational outputs are 0 while psel = 0.
- Slave decode:
  - hit_i = psel & (paddr[15:8] == BASE_PAGE+i).
  - s_psel[i] = hit_i & (state != ABORT).
  - s_penable = penable & (state != ABORT).
  - s_paddr, s_pwdata and s_pwrite are passed through.
- Slave access:
  - prdata and pready are muxed from the hit slave with no added latency.
- Hub-page access:
  - Zero wait: pready = 1 in the access cycle.
  - Writes take effect on the clock edge that ends the access cycle.
- Unmapped page:
  - pready = 1 in the access cycle, prdata = 8'hFF.
  - Sets ERR_FLAG and writes paddr[15:8] to ERR_PAGE.
- FSM states and transitions:
  - IDLE -> FWD on psel & penable & slave hit & !s_pready.
  - FWD counts consecutive access cycles with s_pready low.
  - FWD -> IDLE on s_pready.
  - FWD -> ABORT when the count reaches TIMEOUT.
  - ABORT (exactly one cycle): pready = 1, prdata = 8'hFF, slave psel/penable forced to 0, ERR_FLAG and ERR_PAGE recorded; then -> IDLE.
  - A slave pready arriving in the same cycle the count reaches TIMEOUT wins: normal completion, no error.
  - Dropping psel mid-FWD is a protocol violation: the FSM returns to IDLE and the counter clears.
- Registers (offset = paddr[7:0] in HUB_PAGE; unlisted offsets read 0 and ignore writes):
  - 0x00 INT_PENDING: read. Writing 1 clears edge-mode bits; level-mode bits ignore writes.
  - 0x01 INT_MASK: read/write; 1 = enabled.
  - 0x02 INT_EDGE: read/write; 1 = rising-edge mode, 0 = level mode.
  - 0x03 ERR_STATUS: bit7 = ERR_FLAG. A write of any value clears ERR_FLAG; ERR_PAGE is retained.
  - 0x04 ERR_PAGE: read-only.
  - Bits at index NUM_SLAVES and above read 0.
- Interrupt logic:
  - Level mode: pending[i] = irq_in[i], live.
  - Edge mode: pending[i] sets on irq_in[i] 0->1 versus the registered previous value, and clears on write-1.
  - A set in the same cycle as a clear wins.
  - Toggling INT_EDGE clears that pending bit.
- n_int register:
  - n_int <= ~|(pending & mask), registered.
  - One cycle of latency from a pending/mask change.
- ERR_FLAG/ERR_PAGE:
  - Sticky.
  - A new error in the same cycle as a clear write leaves ERR_FLAG set.

Optional Feature:
- Macro: APB_PERIPH_HUB_TIMEOUT_EN.
- Defined: FWD counter and ABORT state are present as described.
- Undefined:
  - No counter and no ABORT state; a slave stall holds the master indefinitely.
  - Only unmapped-page accesses set ERR_FLAG.

Decomposition:
- Package apb_periph_hub_pkg holds:
  - Register offset constants: REG_INT_PENDING, REG_INT_MASK, REG_INT_EDGE, REG_ERR_STATUS, REG_ERR_PAGE.
  - FSM enum hub_state_t {IDLE, FWD, ABORT}.
  - ERR_RDATA = 8'hFF.
- Sub-module apb_periph_hub_int_ctrl holds the pending/mask/edge registers and the n_int register.
- The top contains the decode, mux, FSM and error registers.

Test Plan:
- Read page 0x01 offset 0x05 while slave 1 returns 8'hA5 with pready after 3 wait cycles -> s_psel = 4'b0010, prdata = 8'hA5, pready high in the 4th access cycle, ERR_FLAG = 0.
- Read 0x3000 with NUM_SLAVES = 4 -> pready in the first access cycle, prdata = 8'hFF; reading 0xFF03 returns 8'h80, 0xFF04 returns 8'h30.
- Access slave 2 and hold its pready low -> 64 FWD cycles, then one ABORT cycle with pready = 1, prdata = 8'hFF, s_psel = 0; ERR_PAGE = 8'h02; writing 0xFF03 clears ERR_FLAG.
- Slave pready arrives exactly on cycle 64 -> normal completion, ERR_FLAG stays 0.
- INT_MASK = 8'h01, INT_EDGE = 8'h01, pulse irq_in[0] for one cycle -> n_int low 2 cycles later and held; write 8'h01 to 0xFF00 -> n_int high one cycle later. Repeat with an irq edge in the clear cycle -> n_int stays low.
- Level mode, irq_in[1] high, mask bit 1 = 0 -> n_int = 1; set mask bit 1 -> n_int low; assert n_rst mid-FWD -> FSM IDLE, n_int = 1, all registers 0.

Source files
------------

// File: rtl/apb_periph_hub_pkg.sv
// Shared constants and types for the APB peripheral hub: hub register offsets,
// the forwarding FSM state type and the error read-data pattern.
package apb_periph_hub_pkg;

    localparam logic [7:0] REG_INT_PENDING = 8'h00;
    localparam logic [7:0] REG_INT_MASK    = 8'h01;
    localparam logic [7:0] REG_INT_EDGE    = 8'h02;
    localparam logic [7:0] REG_ERR_STATUS  = 8'h03;
    localparam logic [7:0] REG_ERR_PAGE    = 8'h04;

    localparam logic [7:0] ERR_RDATA = 8'hFF;

    typedef enum logic [1:0] {IDLE, FWD, ABORT} hub_state_t;

endpackage

// File: rtl/apb_periph_hub_int_ctrl.sv
// Interrupt aggregation: per-slave mask, level/edge mode and pending state,
// folded into the registered active-low n_int line.
module apb_periph_hub_int_ctrl
    import apb_periph_hub_pkg::*;
#(
    parameter int unsigned NUM_SLAVES = 4
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  wr_en,
    input  logic [7:0]            wr_offset,
    input  logic [NUM_SLAVES-1:0] wdata,
    input  logic [NUM_SLAVES-1:0] irq_in,
    output logic [NUM_SLAVES-1:0] pending,
    output logic [NUM_SLAVES-1:0] mask,
    output logic [NUM_SLAVES-1:0] edge_mode,
    output logic                  n_int
);

    logic [NUM_SLAVES-1:0] pend_q;
    logic [NUM_SLAVES-1:0] irq_prev;
    logic [NUM_SLAVES-1:0] rise;
    logic [NUM_SLAVES-1:0] clr;
    logic [NUM_SLAVES-1:0] toggle;
    logic [NUM_SLAVES-1:0] mask_d;
    logic [NUM_SLAVES-1:0] edge_d;

    always_comb begin
        mask_d = mask;
        edge_d = edge_mode;
        clr    = '0;
        if (wr_en) begin
            case (wr_offset)
                REG_INT_PENDING: clr    = wdata;
                REG_INT_MASK:    mask_d = wdata;
                REG_INT_EDGE:    edge_d = wdata;
                default: ;
            endcase
        end
        rise   = irq_in & ~irq_prev;
        toggle = edge_d ^ edge_mode;
    end

    // pend_q only ever holds edge-mode bits; level-mode bits follow irq_in live
    assign pending = pend_q | (irq_in & ~edge_mode);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pend_q    <= '0;
            irq_prev  <= '0;
            mask      <= '0;
            edge_mode <= '0;
            n_int     <= 1'b1;
        end else begin
            pend_q    <= ((pend_q & ~clr & ~toggle) | rise) & edge_d;
            irq_prev  <= irq_in;
            mask      <= mask_d;
            edge_mode <= edge_d;
            n_int     <= ~|(pending & mask);
        end
    end

endmodule

// File: rtl/apb_periph_hub.sv
// APB I/O hub: page decode to up to 8 slaves, read mux, hub registers, error
// capture. Define APB_PERIPH_HUB_TIMEOUT_EN to enable the stall-timeout FSM.
module apb_periph_hub
    import apb_periph_hub_pkg::*;
#(
    parameter int unsigned NUM_SLAVES = 4,
    parameter logic [7:0]  BASE_PAGE  = 8'h00,
    parameter logic [7:0]  HUB_PAGE   = 8'hFF,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic [15:0]             paddr,
    input  logic [7:0]              pwdata,
    input  logic                    pwrite,
    input  logic                    psel,
    input  logic                    penable,
    output logic [7:0]              prdata,
    output logic                    pready,
    output logic [7:0]              s_paddr,
    output logic [7:0]              s_pwdata,
    output logic                    s_pwrite,
    output logic                    s_penable,
    output logic [NUM_SLAVES-1:0]   s_psel,
    input  logic [8*NUM_SLAVES-1:0] s_prdata,
    input  logic [NUM_SLAVES-1:0]   s_pready,
    input  logic [NUM_SLAVES-1:0]   irq_in,
    output logic                    n_int
);

    logic [7:0]            page;
    logic [NUM_SLAVES-1:0] hit;
    logic                  any_hit;
    logic                  hub_sel;
    logic                  unmapped;
    logic                  access;
    logic                  hub_wr;
    logic                  slave_ready;
    logic [7:0]            slave_rdata;
    logic [7:0]            reg_rdata;
    logic                  aborting;
    logic                  err_flag;
    logic [7:0]            err_page;
    logic                  err_set;
    logic                  err_clr;
    logic [NUM_SLAVES-1:0] pending;
    logic [NUM_SLAVES-1:0] mask;
    logic [NUM_SLAVES-1:0] edge_mode;

    assign page      = paddr[15:8];
    assign access    = psel & penable;
    assign s_paddr   = paddr[7:0];
    assign s_pwdata  = pwdata;
    assign s_pwrite  = pwrite;

    always_comb begin
        hit         = '0;
        slave_ready = 1'b0;
        slave_rdata = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (psel && (page == BASE_PAGE + 8'(i))) begin
                hit[i]      = 1'b1;
                slave_ready = s_pready[i];
                slave_rdata = s_prdata[8*i +: 8];
            end
        end
    end

    assign any_hit  = |hit;
    assign hub_sel  = psel & ~any_hit & (page == HUB_PAGE);
    assign unmapped = psel & ~any_hit & (page != HUB_PAGE);
    assign hub_wr   = access & hub_sel & pwrite;

`ifdef APB_PERIPH_HUB_TIMEOUT_EN
    hub_state_t state;
    hub_state_t state_d;
    logic [7:0] cnt;
    logic [7:0] cnt_d;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    // cnt holds the number of stalled access cycles seen in FWD; a ready in the
    // cycle the count reaches TIMEOUT is checked first and completes normally
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        case (state)
            IDLE: begin
                cnt_d = '0;
                if (access && any_hit && !slave_ready) begin
                    state_d = FWD;
                    cnt_d   = 8'd1;
                end
            end
            FWD: begin
                if (!access || slave_ready) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt == 8'(TIMEOUT)) begin
                    state_d = ABORT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + 8'd1;
                end
            end
            ABORT: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        aborting = (state == ABORT);
    end
`else
    assign aborting = 1'b0;
`endif

    always_comb begin
        s_psel    = aborting ? '0 : hit;
        s_penable = penable & ~aborting;
        pready    = 1'b0;
        prdata    = '0;
        if (aborting) begin
            pready = 1'b1;
            prdata = ERR_RDATA;
        end else if (any_hit) begin
            pready = slave_ready;
            prdata = slave_rdata;
        end else if (hub_sel) begin
            pready = penable;
            prdata = reg_rdata;
        end else if (psel) begin
            pready = penable;
            prdata = ERR_RDATA;
        end
    end

    always_comb begin
        reg_rdata = '0;
        case (paddr[7:0])
            REG_INT_PENDING: reg_rdata = 8'(pending);
            REG_INT_MASK:    reg_rdata = 8'(mask);
            REG_INT_EDGE:    reg_rdata = 8'(edge_mode);
            REG_ERR_STATUS:  reg_rdata = {err_flag, 7'b0};
            REG_ERR_PAGE:    reg_rdata = err_page;
            default:         reg_rdata = '0;
        endcase
    end

    assign err_set = (access & unmapped) | aborting;
    assign err_clr = hub_wr & (paddr[7:0] == REG_ERR_STATUS);

    // a new error outranks a clear landing on the same edge
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            err_flag <= 1'b0;
            err_page <= '0;
        end else if (err_set) begin
            err_flag <= 1'b1;
            err_page <= page;
        end else if (err_clr) begin
            err_flag <= 1'b0;
        end
    end

    apb_periph_hub_int_ctrl #(
        .NUM_SLAVES(NUM_SLAVES)
    ) u_int_ctrl (
        .clk       (clk),
        .n_rst     (n_rst),
        .wr_en     (hub_wr),
        .wr_offset (paddr[7:0]),
        .wdata     (pwdata[NUM_SLAVES-1:0]),
        .irq_in    (irq_in),
        .pending   (pending),
        .mask      (mask),
        .edge_mode (edge_mode),
        .n_int     (n_int)
    );

endmodule

// File: tb/tb_apb_periph_hub.sv
// Self-checking bench for apb_periph_hub: APB master tasks push expected
// completions to a queue, popped and compared when pready is observed.
module tb_apb_periph_hub;

    logic        clk;
    logic        n_rst;
    logic [15:0] paddr;
    logic [7:0]  pwdata;
    logic        pwrite;
    logic        psel;
    logic        penable;
    logic [7:0]  prdata;
    logic        pready;
    logic [7:0]  s_paddr;
    logic [7:0]  s_pwdata;
    logic        s_pwrite;
    logic        s_penable;
    logic [3:0]  s_psel;
    logic [31:0] s_prdata;
    logic [3:0]  s_pready;
    logic [3:0]  irq_in;
    logic        n_int;

    int unsigned n_checks;
    int unsigned n_errors;

    typedef struct {
        string       tag;
        logic [7:0]  rdata;
        bit          chk_data;
        int unsigned cycle;
        logic [3:0]  psel_exp;
    } exp_t;

    exp_t exp_q[$];

    apb_periph_hub #(
        .NUM_SLAVES(4),
        .BASE_PAGE (8'h00),
        .HUB_PAGE  (8'hFF),
        .TIMEOUT   (64)
    ) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .pwrite    (pwrite),
        .psel      (psel),
        .penable   (penable),
        .prdata    (prdata),
        .pready    (pready),
        .s_paddr   (s_paddr),
        .s_pwdata  (s_pwdata),
        .s_pwrite  (s_pwrite),
        .s_penable (s_penable),
        .s_psel    (s_psel),
        .s_prdata  (s_prdata),
        .s_pready  (s_pready),
        .irq_in    (irq_in),
        .n_int     (n_int)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One APB transfer; 'stall' is the number of access cycles the addressed
    // slave holds s_pready low. irq0 raises irq_in[0] in the access cycle.
    task automatic xfer(input string tag, input logic [15:0] addr, input logic wr,
                        input logic [7:0] wdata, input int unsigned stall,
                        input logic [7:0] sdata, input logic [7:0] exp_rd,
                        input bit chk_rd, input int unsigned exp_cycle,
                        input logic [3:0] exp_psel, input bit irq0);
        exp_t        e;
        bit          done;
        logic [7:0]  pg;
        pg = addr[15:8];
        e.tag = tag; e.rdata = exp_rd; e.chk_data = chk_rd;
        e.cycle = exp_cycle; e.psel_exp = exp_psel;
        exp_q.push_back(e);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; paddr = addr; pwrite = wr; pwdata = wdata;
        for (int j = 0; j < 4; j++)
            s_prdata[8*j +: 8] = (pg == 8'(j)) ? sdata : (8'h5A ^ 8'(j));
        @(negedge clk);
        penable = 1'b1;
        if (irq0) irq_in[0] = 1'b1;
        done = 1'b0;
        for (int unsigned k = 0; k < 300 && !done; k++) begin
            if (k > 0) @(negedge clk);
            s_pready = (pg < 8'd4 && k >= stall) ? (4'b0001 << pg[1:0]) : 4'b0000;
            #1;
            if (pready) begin
                e = exp_q.pop_front();
                check({e.tag, "_cycle"}, 32'(k + 1), 32'(e.cycle));
                if (e.chk_data) check({e.tag, "_rdata"}, 32'(prdata), 32'(e.rdata));
                check({e.tag, "_psel"}, 32'(s_psel), 32'(e.psel_exp));
                done = 1'b1;
            end
        end
        if (!done) begin
            e = exp_q.pop_front();
            check({e.tag, "_no_pready"}, 32'd0, 32'd1);
        end
        @(negedge clk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; s_pready = '0;
    endtask

    task automatic rd_hub(input string tag, input logic [7:0] off, input logic [7:0] exp);
        xfer(tag, {8'hFF, off}, 1'b0, 8'h00, 0, 8'h00, exp, 1'b1, 1, 4'b0000, 1'b0);
    endtask

    task automatic wr_hub(input string tag, input logic [7:0] off, input logic [7:0] data, input bit irq0);
        xfer(tag, {8'hFF, off}, 1'b1, data, 0, 8'h00, 8'h00, 1'b0, 1, 4'b0000, irq0);
    endtask

    initial begin
        n_checks = 0; n_errors = 0;
        n_rst = 1'b0; paddr = '0; pwdata = '0; pwrite = 1'b0; psel = 1'b0;
        penable = 1'b0; s_prdata = '0; s_pready = '0; irq_in = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_n_int", 32'(n_int), 32'd1);
        check("rst_pready", 32'(pready), 32'd0);
        check("rst_prdata", 32'(prdata), 32'd0);
        check("rst_s_psel", 32'(s_psel), 32'd0);
        n_rst = 1'b1;
        for (int r = 0; r < 5; r++) rd_hub("rst_reg", 8'(r), 8'h00);

        // slave 1 read with 3 wait cycles
        xfer("s1_rd", 16'h0105, 1'b0, 8'h00, 3, 8'hA5, 8'hA5, 1'b1, 4, 4'b0010, 1'b0);
        rd_hub("s1_errflag", 8'h03, 8'h00);

        // unmapped page
        xfer("unmap_rd", 16'h3000, 1'b0, 8'h00, 0, 8'h00, 8'hFF, 1'b1, 1, 4'b0000, 1'b0);
        rd_hub("unmap_errflag", 8'h03, 8'h80);
        rd_hub("unmap_errpage", 8'h04, 8'h30);
        wr_hub("unmap_clr", 8'h03, 8'h00, 1'b0);
        rd_hub("unmap_errclr", 8'h03, 8'h00);
        rd_hub("unmap_pagekeep", 8'h04, 8'h30);

`ifdef APB_PERIPH_HUB_TIMEOUT_EN
        // held stall: 1 idle + 64 FWD cycles, ABORT is the 66th access cycle
        xfer("abort_rd", 16'h0210, 1'b0, 8'h00, 255, 8'h77, 8'hFF, 1'b1, 66, 4'b0000, 1'b0);
        rd_hub("abort_errflag", 8'h03, 8'h80);
        rd_hub("abort_errpage", 8'h04, 8'h02);
        wr_hub("abort_clr", 8'h03, 8'h55, 1'b0);
        rd_hub("abort_errclr", 8'h03, 8'h00);
        // ready arrives in the cycle the count reaches TIMEOUT
        xfer("edge_rd", 16'h0211, 1'b0, 8'h00, 64, 8'h3C, 8'h3C, 1'b1, 65, 4'b0100, 1'b0);
        rd_hub("edge_errflag", 8'h03, 8'h00);
`else
        // without timeout a long stall simply holds the master
        xfer("stall_rd", 16'h0210, 1'b0, 8'h00, 100, 8'h3C, 8'h3C, 1'b1, 101, 4'b0100, 1'b0);
        rd_hub("stall_errflag", 8'h03, 8'h00);
`endif

        // edge-mode interrupt on irq_in[0]
        wr_hub("int_mask", 8'h01, 8'h01, 1'b0);
        wr_hub("int_edge", 8'h02, 8'h01, 1'b0);
        rd_hub("int_mask_rd", 8'h01, 8'h01);
        rd_hub("int_edge_rd", 8'h02, 8'h01);
        check("int_idle_n_int", 32'(n_int), 32'd1);
        irq_in[0] = 1'b1;
        @(negedge clk); irq_in[0] = 1'b0;
        check("pulse_n_int_1cyc", 32'(n_int), 32'd1);
        @(negedge clk);
        check("pulse_n_int_2cyc", 32'(n_int), 32'd0);
        repeat (3) @(negedge clk);
        check("pulse_n_int_held", 32'(n_int), 32'd0);
        rd_hub("pend_rd", 8'h00, 8'h01);
        wr_hub("pend_clr", 8'h00, 8'h01, 1'b0);
        check("clr_n_int_edge", 32'(n_int), 32'd0);
        @(negedge clk);
        check("clr_n_int_after", 32'(n_int), 32'd1);

        irq_in[0] = 1'b1;
        @(negedge clk); irq_in[0] = 1'b0;
        repeat (2) @(negedge clk);
        check("pulse2_n_int", 32'(n_int), 32'd0);
        wr_hub("pend_clr_race", 8'h00, 8'h01, 1'b1);
        check("race_n_int_0", 32'(n_int), 32'd0);
        @(negedge clk);
        check("race_n_int_1", 32'(n_int), 32'd0);
        rd_hub("race_pend_rd", 8'h00, 8'h01);
        irq_in[0] = 1'b0;
        wr_hub("pend_clr2", 8'h00, 8'h01, 1'b0);
        @(negedge clk);
        check("clr2_n_int", 32'(n_int), 32'd1);

        // level mode on irq_in[1]
        wr_hub("edge_off", 8'h02, 8'h00, 1'b0);
        irq_in[1] = 1'b1;
        repeat (2) @(negedge clk);
        check("lvl_masked_n_int", 32'(n_int), 32'd1);
        rd_hub("lvl_pend_rd", 8'h00, 8'h02);
        wr_hub("lvl_mask", 8'h01, 8'h02, 1'b0);
        check("lvl_n_int_edge", 32'(n_int), 32'd1);
        @(negedge clk);
        check("lvl_n_int_low", 32'(n_int), 32'd0);
        rd_hub("lvl_bad_off", 8'h07, 8'h00);

        // asynchronous reset while a slave access is stalled
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; paddr = 16'h0003; pwrite = 1'b0;
        @(negedge clk);
        penable = 1'b1; s_pready = '0;
        repeat (5) @(negedge clk);
        n_rst = 1'b0;
        #1;
        check("rst_mid_n_int", 32'(n_int), 32'd1);
        check("rst_mid_pready", 32'(pready), 32'd0);
        @(negedge clk);
        psel = 1'b0; penable = 1'b0; irq_in = '0;
        @(negedge clk);
        n_rst = 1'b1;
        for (int r = 0; r < 5; r++) rd_hub("rst2_reg", 8'(r), 8'h00);
        xfer("post_rst_rd", 16'h0007, 1'b0, 8'h00, 0, 8'hC3, 8'hC3, 1'b1, 1, 4'b0001, 1'b0);
        check("post_rst_n_int", 32'(n_int), 32'd1);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
